// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Tracks the up/down state of a configurable set of PS/2 keys from decoded
//   scan-code strobes and produces registered press/release/unmapped pulses.
//   Optional typematic-style auto-repeat for the most recently pressed key is
//   built only when the macro KEY_AUTOREPEAT_EN is defined.
//
// Ports
//   clk_100mhz   in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   scan_valid   in   one-cycle strobe: scan_code/scan_ext/scan_break valid
//   scan_code    in   [7:0] scan code byte
//   scan_ext     in   code carried the E0 prefix
//   scan_break   in   code carried the F0 prefix (release)
//   clear        in   synchronous drop of all held keys (wins over scan_valid)
//   key_held     out  [NUM_KEYS-1:0] level, key currently down
//   key_press    out  [NUM_KEYS-1:0] one-cycle pulse, press or auto-repeat
//   key_release  out  [NUM_KEYS-1:0] one-cycle pulse, release
//   unmapped     out  one-cycle pulse, scan with no matching key
module ps2_key_tracker #(
   parameter int unsigned             NUM_KEYS      = 5,
   parameter logic [NUM_KEYS*8-1:0]   KEY_CODES     = {8'h23, 8'h1b, 8'h1d, 8'h1c, 8'h29},
   parameter logic [NUM_KEYS-1:0]     KEY_EXT       = '0,
   parameter int unsigned             REPEAT_DELAY  = 50_000_000,
   parameter int unsigned             REPEAT_PERIOD = 10_000_000
) (
   input  logic                clk_100mhz,
   input  logic                rst_n,
   input  logic                scan_valid,
   input  logic [7:0]          scan_code,
   input  logic                scan_ext,
   input  logic                scan_break,
   input  logic                clear,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                unmapped
);

   localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_bad_num_keys
      $error("ps2_key_tracker: NUM_KEYS must be 1..32");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("ps2_key_tracker: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic                hit;
   logic [KW-1:0]       hit_idx;
   logic [NUM_KEYS-1:0] hit_vec;
   logic                is_held;
   logic                new_press;
   logic                held_break;

   logic [NUM_KEYS-1:0] held_nxt;
   logic [NUM_KEYS-1:0] press_nxt;
   logic [NUM_KEYS-1:0] release_nxt;
   logic                unmapped_nxt;
   logic [NUM_KEYS-1:0] rep_vec;

   // Lowest matching index wins when KEY_CODES holds duplicate entries.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (!hit && scan_code == KEY_CODES[8*i +: 8] && scan_ext == KEY_EXT[i]) begin
            hit     = 1'b1;
            hit_idx = KW'(i);
         end
      end
   end

   assign hit_vec    = hit ? (NUM_KEYS'(1) << hit_idx) : '0;
   assign is_held    = |(hit_vec & key_held);
   assign new_press  = scan_valid && !clear && hit && !scan_break && !is_held;
   assign held_break = scan_valid && !clear && hit &&  scan_break &&  is_held;

   always_comb begin
      held_nxt     = key_held;
      press_nxt    = '0;
      release_nxt  = '0;
      unmapped_nxt = 1'b0;
      if (clear) begin
         held_nxt = '0;
      end else if (scan_valid) begin
         if (!hit) begin
            unmapped_nxt = 1'b1;
         end else if (new_press) begin
            held_nxt  = key_held | hit_vec;
            press_nxt = hit_vec;
         end else if (held_break) begin
            held_nxt    = key_held & ~hit_vec;
            release_nxt = hit_vec;
         end
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rep_state_t;

   rep_state_t    rep_state, rep_state_nxt;
   logic [CW-1:0] rep_cnt,   rep_cnt_nxt;
   logic [KW-1:0] rep_key,   rep_key_nxt;
   logic          rep_fire;

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         rep_state <= IDLE;
         rep_cnt   <= '0;
         rep_key   <= '0;
      end else begin
         rep_state <= rep_state_nxt;
         rep_cnt   <= rep_cnt_nxt;
         rep_key   <= rep_key_nxt;
      end
   end

   // Expiry is evaluated first; clear, a new press or a break of the tracked
   // key then override it, which drops any coincident repeat pulse.
   always_comb begin
      rep_state_nxt = rep_state;
      rep_cnt_nxt   = rep_cnt;
      rep_key_nxt   = rep_key;
      rep_fire      = 1'b0;
      case (rep_state)
         DELAY, REPEAT: begin
            if (rep_cnt == CW'(1)) begin
               rep_fire      = 1'b1;
               rep_state_nxt = REPEAT;
               rep_cnt_nxt   = CW'(REPEAT_PERIOD);
            end else begin
               rep_cnt_nxt = rep_cnt - CW'(1);
            end
         end
         default: ;
      endcase
      if (clear) begin
         rep_state_nxt = IDLE;
         rep_cnt_nxt   = '0;
         rep_fire      = 1'b0;
      end else if (new_press) begin
         rep_state_nxt = DELAY;
         rep_cnt_nxt   = CW'(REPEAT_DELAY);
         rep_key_nxt   = hit_idx;
         rep_fire      = 1'b0;
      end else if (held_break && rep_state != IDLE && hit_idx == rep_key) begin
         rep_state_nxt = IDLE;
         rep_cnt_nxt   = '0;
         rep_fire      = 1'b0;
      end
   end

   assign rep_vec = rep_fire ? (NUM_KEYS'(1) << rep_key) : '0;
`else
   assign rep_vec = '0;
`endif

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         key_held    <= '0;
         key_press   <= '0;
         key_release <= '0;
         unmapped    <= 1'b0;
      end else begin
         key_held    <= held_nxt;
         key_press   <= press_nxt | rep_vec;
         key_release <= release_nxt;
         unmapped    <= unmapped_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
//   Self-checking bench for ps2_key_tracker (5 default keys, REPEAT_DELAY=20,
//   REPEAT_PERIOD=5). A timestamp-based reference model predicts every output
//   each cycle; directed sequences are followed by randomized scan traffic.
module tb_ps2_key_tracker;

   localparam int unsigned RD = 20;
   localparam int unsigned RP = 5;

   logic       clk_100mhz;
   logic       rst_n;
   logic       scan_valid;
   logic [7:0] scan_code;
   logic       scan_ext;
   logic       scan_break;
   logic       clear;
   logic [4:0] key_held;
   logic [4:0] key_press;
   logic [4:0] key_release;
   logic       unmapped;

   ps2_key_tracker #(
      .NUM_KEYS      (5),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk_100mhz  (clk_100mhz),
      .rst_n       (rst_n),
      .scan_valid  (scan_valid),
      .scan_code   (scan_code),
      .scan_ext    (scan_ext),
      .scan_break  (scan_break),
      .clear       (clear),
      .key_held    (key_held),
      .key_press   (key_press),
      .key_release (key_release),
      .unmapped    (unmapped)
   );

   initial begin
      clk_100mhz = 1'b0;
      forever #5 clk_100mhz = ~clk_100mhz;
   end

   // key i scan codes: space, a, w, s, d; none extended
   logic [7:0] codes [5] = '{8'h29, 8'h1c, 8'h1d, 8'h1b, 8'h23};

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // reference model state
   logic [4:0]  m_held;
   logic [4:0]  e_press;
   logic [4:0]  e_release;
   logic        e_unmapped;
   bit          m_trk_on;
   int          m_trk;
   int          m_t0;
   int          cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
      end
   endtask

   // One clock edge worth of behaviour, from the rules directly.
   task automatic model_step(input logic sv, input logic [7:0] code, input logic ext,
                             input logic brk, input logic clr);
      int  m;
      bit  pressed;
      int  d;
      cyc++;
      e_press    = '0;
      e_release  = '0;
      e_unmapped = 1'b0;
      pressed    = 0;
      if (clr) begin
         m_held   = '0;
         m_trk_on = 0;
      end else begin
         m = -1;
         for (int i = 0; i < 5; i++)
            if (m < 0 && code == codes[i] && ext == 1'b0) m = i;
         if (sv) begin
            if (m < 0) begin
               e_unmapped = 1'b1;
            end else if (!brk && !m_held[m]) begin
               m_held[m]  = 1'b1;
               e_press[m] = 1'b1;
               pressed    = 1;
               m_trk_on   = 1;
               m_trk      = m;
               m_t0       = cyc;
            end else if (brk && m_held[m]) begin
               m_held[m]    = 1'b0;
               e_release[m] = 1'b1;
               if (m_trk_on && m_trk == m) m_trk_on = 0;
            end
         end
`ifdef KEY_AUTOREPEAT_EN
         if (!pressed && m_trk_on) begin
            d = cyc - m_t0;
            if (d == int'(RD) || (d > int'(RD) && ((d - int'(RD)) % int'(RP)) == 0))
               e_press[m_trk] = 1'b1;
         end
`endif
      end
   endtask

   task automatic step(input logic sv, input logic [7:0] code, input logic ext,
                       input logic brk, input logic clr);
      @(negedge clk_100mhz);
      scan_valid = sv;
      scan_code  = code;
      scan_ext   = ext;
      scan_break = brk;
      clear      = clr;
      @(posedge clk_100mhz);
      model_step(sv, code, ext, brk, clr);
      #1;
      check_eq("key_held",    32'(key_held),    32'(m_held));
      check_eq("key_press",   32'(key_press),   32'(e_press));
      check_eq("key_release", 32'(key_release), 32'(e_release));
      check_eq("unmapped",    32'(unmapped),    32'(e_unmapped));
      scan_valid = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset asserted mid-cycle; outputs must drop before any clock edge.
   task automatic do_reset();
      @(negedge clk_100mhz);
      #2;
      scan_valid = 1'b0;
      clear      = 1'b0;
      rst_n      = 1'b0;
      #1;
      check_eq("rst_held",     32'(key_held),    32'h0);
      check_eq("rst_press",    32'(key_press),   32'h0);
      check_eq("rst_release",  32'(key_release), 32'h0);
      check_eq("rst_unmapped", 32'(unmapped),    32'h0);
      repeat (3) @(posedge clk_100mhz);
      #1;
      check_eq("rst_held_hold", 32'(key_held), 32'h0);
      @(negedge clk_100mhz);
      rst_n    = 1'b1;
      m_held   = '0;
      m_trk_on = 0;
   endtask

   initial begin
      int unsigned npress;
      int unsigned r;
      logic [7:0]  code;
      rst_n      = 1'b1;
      scan_valid = 1'b0;
      scan_code  = 8'h00;
      scan_ext   = 1'b0;
      scan_break = 1'b0;
      clear      = 1'b0;
      m_held     = '0;
      m_trk_on   = 0;
      m_trk      = 0;
      m_t0       = 0;
      do_reset();

      // make 0x1d, then typematic make of the same key
      step(1'b1, 8'h1d, 1'b0, 1'b0, 1'b0);
      check_eq("press_1d", 32'(key_press), 32'h04);
      idle(2);
      step(1'b1, 8'h1d, 1'b0, 1'b0, 1'b0);
      check_eq("typematic_no_pulse", 32'(key_press), 32'h0);
      step(1'b1, 8'h1d, 1'b0, 1'b1, 1'b0);
      idle(1);

      // two keys held, one released
      step(1'b1, 8'h1c, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h1c, 1'b0, 1'b1, 1'b0);
      check_eq("release_1c", 32'(key_release), 32'h02);
      idle(1);
      step(1'b1, 8'h23, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h23, 1'b0, 1'b1, 1'b0);   // break of key not held

      // unmapped codes, including extended variant of a mapped code
      step(1'b1, 8'h15, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h29, 1'b1, 1'b0, 1'b0);
      check_eq("ext_unmapped", 32'(unmapped), 32'h1);

      // hold 0x29 for 40 cycles, count press pulses
      npress = 0;
      step(1'b1, 8'h29, 1'b0, 1'b0, 1'b0);
      if (key_press[0]) npress++;
      for (int i = 0; i < 39; i++) begin
         idle(1);
         if (key_press[0]) npress++;
      end
`ifdef KEY_AUTOREPEAT_EN
      check_eq("repeat_count", npress, 5);
`else
      check_eq("repeat_count", npress, 1);
`endif
      step(1'b1, 8'h29, 1'b0, 1'b1, 1'b0);
      idle(12);

      // repeat expiry coinciding with a new press of another key
      step(1'b1, 8'h29, 1'b0, 1'b0, 1'b0);
      idle(RD - 1);
      step(1'b1, 8'h1d, 1'b0, 1'b0, 1'b0);
      check_eq("coincide_press", 32'(key_press), 32'h04);
      idle(RD + 2 * RP);
      // break of the non-tracked key leaves repeats running; then break tracked key at expiry
      step(1'b1, 8'h29, 1'b0, 1'b1, 1'b0);
      idle(RD - 2);
      step(1'b1, 8'h1d, 1'b0, 1'b1, 1'b0);
      check_eq("break_at_expiry", 32'(key_press), 32'h0);
      idle(10);

      // reset mid-sequence, then break produces nothing
      step(1'b1, 8'h1b, 1'b0, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 8'h1b, 1'b0, 1'b1, 1'b0);
      check_eq("post_rst_break", 32'(key_release), 32'h0);

      // clear wins over a same-cycle make
      step(1'b1, 8'h1c, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h23, 1'b0, 1'b0, 1'b1);
      check_eq("clear_held", 32'(key_held), 32'h0);
      check_eq("clear_press", 32'(key_press), 32'h0);
      idle(RD + 2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         end else if (r < 35) begin
            case ($urandom_range(0, 7))
               0:       code = 8'($urandom);
               1:       code = 8'h15;
               default: code = codes[$urandom_range(0, 4)];
            endcase
            step(1'b1, code, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));
         end else begin
            idle(1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
